// File: rtl/sfx_tone_mixer_pkg.sv
// sfx_tone_mixer_pkg: shared mix-mode constants, channel state type and saturation helper.
package sfx_tone_mixer_pkg;
    localparam int MIX_PRIORITY = 0;
    localparam int MIX_SUM = 1;
    localparam logic [31:0] AMP_DEFAULT = 32'd10000000;

    typedef enum logic {IDLE, PLAY} chan_state_t;

    // Returns {positive overflow, negative overflow} of x against a signed w-bit range.
    function automatic logic [1:0] sat_flags(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        return {x > hi, x < -hi - 64'sd1};
    endfunction
endpackage

// File: rtl/sfx_tone_mixer_if.sv
// sfx_tone_mixer_if: sample and handshake bundle between the tone mixer and Audio_Controller.
interface sfx_tone_mixer_if #(parameter int SAMPLE_W = 32);
    logic signed [SAMPLE_W-1:0] left_in, right_in, left_out, right_out;
    logic audio_in_available, audio_out_allowed, read_audio_in, write_audio_out;

    modport master (
        output left_in, right_in, audio_in_available, audio_out_allowed,
        input  left_out, right_out, read_audio_in, write_audio_out
    );
    modport slave (
        input  left_in, right_in, audio_in_available, audio_out_allowed,
        output left_out, right_out, read_audio_in, write_audio_out
    );
endinterface

// File: rtl/sfx_tone_mixer_channel.sv
// sfx_tone_mixer_channel: one square-tone voice with programmable half-period and duration.
module sfx_tone_mixer_channel
    import sfx_tone_mixer_pkg::*;
#(
    parameter int HALF_W = 19,
    parameter int DUR_W  = 26
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              rise_i,
    input  logic [HALF_W-1:0] half_period_i,
    input  logic [DUR_W-1:0]  duration_i,
    output logic              active_o,
    output logic              pol_o
);
    chan_state_t       state_q;
    logic [HALF_W-1:0] half_q, phase_q, last_phase;
    logic [DUR_W-1:0]  dur_q;
    logic              pol_q;

    // A zero half-period behaves like one: toggle every cycle.
    assign last_phase = (half_q == '0) ? '0 : half_q - 1'b1;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q <= IDLE;
            half_q  <= '0;
            phase_q <= '0;
            dur_q   <= '0;
            pol_q   <= 1'b0;
        end else if (rise_i && duration_i != '0) begin
            state_q <= PLAY;
            half_q  <= half_period_i;
            phase_q <= '0;
            dur_q   <= duration_i;
            pol_q   <= 1'b1;
        end else if (state_q == PLAY) begin
            state_q <= (dur_q == DUR_W'(1)) ? IDLE : PLAY;
            dur_q   <= dur_q - 1'b1;
            phase_q <= (phase_q == last_phase) ? '0 : phase_q + 1'b1;
            pol_q   <= pol_q ^ (phase_q == last_phase);
        end
    end

    assign active_o = (state_q == PLAY);
    assign pol_o    = pol_q;
endmodule

// File: rtl/sfx_tone_mixer.sv
// sfx_tone_mixer: multi-channel sound-effect tones mixed onto the codec pass-through,
// handed to Audio_Controller through the available/allowed handshake.
module sfx_tone_mixer
    import sfx_tone_mixer_pkg::*;
#(
    parameter int                  NUM_CH   = 4,
    parameter int                  HALF_W   = 19,
    parameter int                  DUR_W    = 26,
    parameter int                  SAMPLE_W = 32,
    parameter logic [SAMPLE_W-1:0] AMP      = AMP_DEFAULT,
    parameter int                  MIX_MODE = MIX_PRIORITY
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic [NUM_CH-1:0]        trigger,
    input  logic [NUM_CH*HALF_W-1:0] half_period,
    input  logic [NUM_CH*DUR_W-1:0]  duration,
    input  logic                     mute,
    sfx_tone_mixer_if.slave          aud,
    output logic [NUM_CH-1:0]        active,
    output logic                     busy
);
    localparam int MW = SAMPLE_W + $clog2(NUM_CH) + 1;
    localparam logic signed [MW-1:0]       AMP_M = MW'(AMP);
    localparam logic signed [SAMPLE_W-1:0] AMP_S = AMP;
    localparam logic signed [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [NUM_CH-1:0]          trig_q, pol;
    logic signed [SAMPLE_W-1:0] tone_q, tone_d, pri;
    logic signed [MW-1:0]       sum;
    logic signed [SAMPLE_W:0]   l_sum, r_sum;

    function automatic logic signed [SAMPLE_W-1:0] clamp(input logic signed [63:0] x);
        logic [1:0] f;
        f = sat_flags(x, SAMPLE_W);
        return f[1] ? S_MAX : (f[0] ? S_MIN : x[SAMPLE_W-1:0]);
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sfx_tone_mixer_channel #(.HALF_W(HALF_W), .DUR_W(DUR_W)) u_ch (
            .CLOCK_50     (CLOCK_50),
            .resetn       (resetn),
            .rise_i       (trigger[c] & ~trig_q[c]),
            .half_period_i(half_period[c*HALF_W +: HALF_W]),
            .duration_i   (duration[c*DUR_W +: DUR_W]),
            .active_o     (active[c]),
            .pol_o        (pol[c])
        );
    end

    // Descending scan so the lowest active index is the last one to set pri.
    always_comb begin
        sum = '0;
        pri = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (active[i]) begin
                sum = sum + (pol[i] ? AMP_M : -AMP_M);
                pri = pol[i] ? AMP_S : -AMP_S;
            end
        end
        tone_d = mute ? '0 : ((MIX_MODE == MIX_SUM) ? clamp(64'(sum)) : pri);
    end

    // Edge-detect resets to ones so a trigger held through reset does not fire.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            trig_q <= '1;
            tone_q <= '0;
        end else begin
            trig_q <= trigger;
            tone_q <= tone_d;
        end
    end

    assign l_sum = (SAMPLE_W+1)'(aud.left_in) + (SAMPLE_W+1)'(tone_q);
    assign r_sum = (SAMPLE_W+1)'(aud.right_in) + (SAMPLE_W+1)'(tone_q);
    assign aud.left_out  = clamp(64'(l_sum));
    assign aud.right_out = clamp(64'(r_sum));
    assign aud.read_audio_in   = aud.audio_in_available & aud.audio_out_allowed;
    assign aud.write_audio_out = aud.audio_in_available & aud.audio_out_allowed;
    assign busy = |active;
endmodule

// File: tb/tb_sfx_tone_mixer.sv
// tb_sfx_tone_mixer: directed bench for priority (d0) and saturating-sum (d1) mixers.
module tb_sfx_tone_mixer;
    localparam logic [31:0] A = 32'd10000000;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [3:0]   trigger = '0;
    logic [75:0]  half_period = '0;
    logic [103:0] duration = '0;
    logic         mute = 1'b0;
    logic [3:0]   act0, act1;
    logic         busy0, busy1;
    int           checks = 0;
    int           errors = 0;

    sfx_tone_mixer_if #(.SAMPLE_W(32)) a0 ();
    sfx_tone_mixer_if #(.SAMPLE_W(32)) a1 ();

    sfx_tone_mixer #(.MIX_MODE(0)) d0 (
        .CLOCK_50(clk), .resetn(resetn), .trigger(trigger), .half_period(half_period),
        .duration(duration), .mute(mute), .aud(a0), .active(act0), .busy(busy0)
    );
    sfx_tone_mixer #(.MIX_MODE(1)) d1 (
        .CLOCK_50(clk), .resetn(resetn), .trigger(trigger), .half_period(half_period),
        .duration(duration), .mute(mute), .aud(a1), .active(act1), .busy(busy1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic av, al;
        logic [31:0] li, ri;
        logic x;
        logic [31:0] lo, ro;
    } vec_t;
    vec_t v [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int i, input int h, input int d);
        half_period[i*19 +: 19] = 19'(h);
        duration[i*26 +: 26]    = 26'(d);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        trigger = '0;
        cyc();
        cyc();
        resetn = 1'b1;
        cyc();
    endtask

    function automatic logic [31:0] tv(input int s);
        return s > 0 ? A : (s < 0 ? -A : 32'h0);
    endfunction

    function automatic logic [31:0] neg_sat(input logic [31:0] t);
        return t[31] ? 32'h8000_0000 : 32'h8000_0000 + t;
    endfunction

    initial begin
        logic [31:0] t;
        v[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0262_5A00, 32'h0262_5A00};
        v[1] = '{1'b1, 1'b0, 32'h7FF0_0000, 32'h8000_0000, 1'b0, 32'h7FFF_FFFF, 32'h8262_5A00};
        v[2] = '{1'b0, 1'b1, 32'h7D9D_A5FF, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 32'h0262_59FF};
        v[3] = '{1'b1, 1'b1, 32'h7D9D_A600, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 32'h0262_5A01};
        v[4] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFD9D_A600, 1'b1, 32'h8262_5A00, 32'h0000_0000};
        v[5] = '{1'b1, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF};

        a0.left_in = 32'h1234_5678; a0.right_in = 32'h8000_0000;
        a0.audio_in_available = 1'b1; a0.audio_out_allowed = 1'b0;
        a1.left_in = '0; a1.right_in = '0;
        a1.audio_in_available = 1'b0; a1.audio_out_allowed = 1'b0;
        do_reset();
        @(negedge clk);
        chk("reset_active", 32'(act0), 32'h0);
        chk("reset_busy", 32'(busy0), 32'h0);
        chk("reset_passthru", a0.left_out, 32'h1234_5678);
        chk("reset_read", 32'(a0.read_audio_in), 32'h0);
        chk("reset_write", 32'(a0.write_audio_out), 32'h0);
        a0.left_in = '0;

        // Single tone: half=3, dur=12 on ch0.
        cfg(0, 3, 12);
        cyc();
        trigger = 4'b0001;
        @(negedge clk);
        chk("t1_active_k", 32'(act0), 32'h0);
        for (int j = 1; j <= 15; j++) begin
            cyc();
            if (j == 1) trigger = '0;
            @(negedge clk);
            t = (j < 2 || j > 13) ? 32'h0 : tv((((j - 2) / 3) % 2 == 0) ? 1 : -1);
            chk($sformatf("t1_active_%0d", j), 32'(act0[0]), 32'((j >= 1 && j <= 12) ? 1 : 0));
            chk($sformatf("t1_busy_%0d", j), 32'(busy0), 32'((j >= 1 && j <= 12) ? 1 : 0));
            chk($sformatf("t1_tone_%0d", j), a0.left_out, t);
            chk($sformatf("t1_negsat_%0d", j), a0.right_out, neg_sat(t));
        end

        // Priority: ch0 masks ch1 until it expires.
        do_reset();
        cfg(0, 2, 6);
        cfg(1, 5, 20);
        trigger = 4'b0011;
        for (int j = 1; j <= 22; j++) begin
            cyc();
            if (j == 1) trigger = '0;
            @(negedge clk);
            if (j < 2 || j > 21) t = 32'h0;
            else if (j <= 7) t = tv((((j - 2) / 2) % 2 == 0) ? 1 : -1);
            else t = tv((((j - 2) / 5) % 2 == 0) ? 1 : -1);
            chk($sformatf("t2_tone_%0d", j), a0.left_out, t);
            chk($sformatf("t2_busy_%0d", j), 32'(busy0), 32'((j <= 20) ? 1 : 0));
        end

        // Retrigger ch2 five cycles into a 10-cycle tone.
        do_reset();
        cfg(2, 4, 10);
        trigger = 4'b0100;
        for (int j = 1; j <= 17; j++) begin
            cyc();
            trigger = (j == 5) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            chk($sformatf("t5_active_%0d", j), 32'(act0[2]), 32'((j <= 15) ? 1 : 0));
            if (j >= 2 && j <= 11)
                chk($sformatf("t5_tone_%0d", j), a0.left_out, tv((j == 6 || j == 11) ? -1 : 1));
        end

        // Reset mid-play with trigger held high.
        do_reset();
        cfg(3, 2, 50);
        trigger = 4'b1000;
        cyc(); cyc(); cyc();
        resetn = 1'b0;
        cyc();
        @(negedge clk);
        chk("t6_active_rst", 32'(act0), 32'h0);
        chk("t6_tone_rst", a0.left_out, 32'h0);
        resetn = 1'b1;
        for (int j = 0; j < 5; j++) cyc();
        @(negedge clk);
        chk("t6_no_restart", 32'(act0), 32'h0);
        trigger = '0;
        cyc();
        trigger = 4'b1000;
        cyc();
        @(negedge clk);
        chk("t6_rearm", 32'(act0), 32'h8);

        // Sum mode saturation and handshake table, all four channels at +A.
        do_reset();
        for (int i = 0; i < 4; i++) cfg(i, 1000, 2000);
        trigger = 4'hF;
        cyc();
        trigger = '0;
        cyc();
        @(negedge clk);
        chk("t3_prio_tone", a0.left_out, A);
        cyc();
        foreach (v[i]) begin
            a1.audio_in_available = v[i].av;
            a1.audio_out_allowed  = v[i].al;
            a1.left_in  = v[i].li;
            a1.right_in = v[i].ri;
            @(negedge clk);
            chk($sformatf("tbl%0d_read", i), 32'(a1.read_audio_in), 32'(v[i].x));
            chk($sformatf("tbl%0d_write", i), 32'(a1.write_audio_out), 32'(v[i].x));
            chk($sformatf("tbl%0d_left", i), a1.left_out, v[i].lo);
            chk($sformatf("tbl%0d_right", i), a1.right_out, v[i].ro);
            cyc();
        end

        mute = 1'b1;
        a1.left_in = 32'h0000_1234;
        cyc();
        cyc();
        @(negedge clk);
        chk("mute_tone", a1.left_out, 32'h0000_1234);
        chk("mute_running", 32'(act1), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
